// File: rtl/register_file_mp.sv
// register_file_mp
//   Parametrised multi-read-port integer register file with a busy scoreboard
//   and a hardware clear engine. x0 is hard-wired to zero. The storage array
//   has no reset. After reset, or on a clr_i pulse, the clear engine walks
//   entries 1..NUM_REGS-1 and writes zero to each. Reads return zero until it
//   finishes, so the array can map onto plain flops or latch-RAM.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   rs_idx_i     packed read indices, port p at [p*IDX_W +: IDX_W]
//   rs_data_ao   packed asynchronous read data, port p at [p*XLEN +: XLEN]
//   wr_en_i      write strobe
//   wr_idx_i     write destination index
//   wr_data_i    write data
//   issue_en_i   mark issue_idx_i as having a pending write
//   issue_idx_i  destination index being issued
//   clr_i        single-cycle request to zero the whole array
//   ready_o      array valid and clear engine idle
//   busy_o       per-register pending-write bits (bit 0 always 0)

module register_file_mp #(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_RD*IDX_W-1:0]  rs_idx_i,
  output logic [NUM_RD*XLEN-1:0]   rs_data_ao,
  input  logic                     wr_en_i,
  input  logic [IDX_W-1:0]         wr_idx_i,
  input  logic [XLEN-1:0]          wr_data_i,
  input  logic                     issue_en_i,
  input  logic [IDX_W-1:0]         issue_idx_i,
  input  logic                     clr_i,
  output logic                     ready_o,
  output logic [NUM_REGS-1:0]      busy_o
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic ready;
  logic wr_ok;
  logic issue_ok;
  logic clr_start;

  // The index width is rounded up to a power of two, so an index can name a
  // register that does not exist. Such indices are treated like x0.
  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return (32'(idx) < NUM_REGS);
  endfunction

  assign ready     = (state_q == ST_IDLE);
  assign ready_o   = ready;
  assign wr_ok     = ready && wr_en_i && (wr_idx_i != '0) && in_range(wr_idx_i);
  assign issue_ok  = ready && issue_en_i && (issue_idx_i != '0) && in_range(issue_idx_i);
  assign clr_start = ready && clr_i;

  // State and clear counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_CLEAR;
      cnt_q   <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear engine sequencing. A clr_i that arrives while a clear is already
  // running is ignored. Only an idle array can be asked to clear again.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + FIRST_IDX;
        end
      end
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = FIRST_IDX;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = FIRST_IDX;
      end
    endcase
  end

  // Storage has deliberately no reset. Entry 0 is never written.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      regs[cnt_q] <= '0;
    end else if (wr_ok) begin
      regs[wr_idx_i] <= wr_data_i;
    end
  end

  // Scoreboard next state. The issue update is applied after the write
  // update, so a newly issued producer keeps the bit set when its
  // predecessor retires in the same cycle.
  always_comb begin
    busy_d = busy_q;
    if (clr_start) begin
      busy_d = '0;
    end else begin
      if (wr_ok) begin
        busy_d[wr_idx_i] = 1'b0;
      end
      if (issue_ok) begin
        busy_d[issue_idx_i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

  // Each read port is independent and purely combinational.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             fwd;

    assign idx   = rs_idx_i[p*IDX_W +: IDX_W];
    assign valid = ready && (idx != '0) && in_range(idx);
    assign fwd   = (BYPASS != 0) && wr_ok && (wr_idx_i == idx);
    assign rs_data_ao[p*XLEN +: XLEN] = !valid ? '0 :
                                        fwd    ? wr_data_i : regs[idx];
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp
//   Checks three configurations of register_file_mp side by side:
//   A: default (64x32, 2 ports, bypass)
//   B: 64x20, 2 ports, no bypass, so some indices are out of range
//   C: 32x16, 3 ports, bypass

module tb_register_file_mp;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Instance A signals
  logic [9:0]   a_rs_idx;
  logic [127:0] a_rd;
  logic         a_wr_en, a_issue_en, a_clr, a_ready;
  logic [4:0]   a_wr_idx, a_issue_idx;
  logic [63:0]  a_wr_data;
  logic [31:0]  a_busy;

  // Instance B signals
  logic [9:0]   b_rs_idx;
  logic [127:0] b_rd;
  logic         b_wr_en, b_issue_en, b_clr, b_ready;
  logic [4:0]   b_wr_idx, b_issue_idx;
  logic [63:0]  b_wr_data;
  logic [19:0]  b_busy;

  // Instance C signals
  logic [11:0]  c_rs_idx;
  logic [95:0]  c_rd;
  logic         c_wr_en, c_issue_en, c_clr, c_ready;
  logic [3:0]   c_wr_idx, c_issue_idx;
  logic [31:0]  c_wr_data;
  logic [15:0]  c_busy;

  int total = 0;
  int bad   = 0;

  register_file_mp dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rs_idx_i(a_rs_idx), .rs_data_ao(a_rd),
    .wr_en_i(a_wr_en), .wr_idx_i(a_wr_idx), .wr_data_i(a_wr_data),
    .issue_en_i(a_issue_en), .issue_idx_i(a_issue_idx), .clr_i(a_clr),
    .ready_o(a_ready), .busy_o(a_busy)
  );

  register_file_mp #(.XLEN(64), .NUM_REGS(20), .NUM_RD(2), .BYPASS(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rs_idx_i(b_rs_idx), .rs_data_ao(b_rd),
    .wr_en_i(b_wr_en), .wr_idx_i(b_wr_idx), .wr_data_i(b_wr_data),
    .issue_en_i(b_issue_en), .issue_idx_i(b_issue_idx), .clr_i(b_clr),
    .ready_o(b_ready), .busy_o(b_busy)
  );

  register_file_mp #(.XLEN(32), .NUM_REGS(16), .NUM_RD(3), .BYPASS(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .rs_idx_i(c_rs_idx), .rs_data_ao(c_rd),
    .wr_en_i(c_wr_en), .wr_idx_i(c_wr_idx), .wr_data_i(c_wr_data),
    .issue_en_i(c_issue_en), .issue_idx_i(c_issue_idx), .clr_i(c_clr),
    .ready_o(c_ready), .busy_o(c_busy)
  );

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [63:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_idx;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [63:0] exp_rd0;
    logic [63:0] exp_rd1;
    logic [31:0] exp_busy;
  } vec_t;

  localparam logic [63:0] K5   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives one vector on instance A, checks the combinational reads in the
  // same cycle, then checks the scoreboard after the edge.
  task automatic applyStimulus(input vec_t v, input int n);
    @(negedge clk);
    a_wr_en     = v.wr_en;
    a_wr_idx    = v.wr_idx;
    a_wr_data   = v.wr_data;
    a_issue_en  = v.issue_en;
    a_issue_idx = v.issue_idx;
    a_rs_idx    = {v.rs1, v.rs0};
    #1;
    checkOutput($sformatf("vec%0d rd0", n), a_rd[63:0], v.exp_rd0);
    checkOutput($sformatf("vec%0d rd1", n), a_rd[127:64], v.exp_rd1);
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d busy", n), {32'h0, a_busy}, {32'h0, v.exp_busy});
  endtask

  initial begin
    int first_a, first_b, first_c;

    vecs[0]  = '{1'b1, 5'd5,  K5,          1'b0, 5'd0,  5'd5,  5'd5,  K5,          K5,          32'h0};
    vecs[1]  = '{1'b0, 5'd0,  64'h0,       1'b0, 5'd0,  5'd5,  5'd5,  K5,          K5,          32'h0};
    vecs[2]  = '{1'b1, 5'd0,  ONES,        1'b0, 5'd0,  5'd0,  5'd5,  64'h0,       K5,          32'h0};
    vecs[3]  = '{1'b0, 5'd0,  64'h0,       1'b0, 5'd0,  5'd0,  5'd6,  64'h0,       64'h0,       32'h0};
    vecs[4]  = '{1'b1, 5'd7,  64'hA5A5,    1'b0, 5'd0,  5'd5,  5'd7,  K5,          64'hA5A5,    32'h0};
    vecs[5]  = '{1'b0, 5'd0,  64'h0,       1'b1, 5'd3,  5'd7,  5'd3,  64'hA5A5,    64'h0,       32'h8};
    vecs[6]  = '{1'b1, 5'd3,  64'h33,      1'b1, 5'd3,  5'd3,  5'd3,  64'h33,      64'h33,      32'h8};
    vecs[7]  = '{1'b1, 5'd3,  64'h44,      1'b0, 5'd0,  5'd3,  5'd0,  64'h44,      64'h0,       32'h0};
    vecs[8]  = '{1'b0, 5'd0,  64'h0,       1'b1, 5'd0,  5'd3,  5'd7,  64'h44,      64'hA5A5,    32'h0};
    vecs[9]  = '{1'b1, 5'd12, 64'hC,       1'b1, 5'd10, 5'd12, 5'd10, 64'hC,       64'h0,       32'h400};
    vecs[10] = '{1'b1, 5'd10, 64'hA,       1'b1, 5'd12, 5'd10, 5'd12, 64'hA,       64'hC,       32'h1000};
    vecs[11] = '{1'b1, 5'd31, ONES,        1'b0, 5'd0,  5'd31, 5'd12, ONES,        64'hC,       32'h1000};
    vecs[12] = '{1'b1, 5'd12, 64'h12,      1'b0, 5'd0,  5'd12, 5'd31, 64'h12,      ONES,        32'h0};

    a_rs_idx = '0; a_wr_en = 0; a_wr_idx = '0; a_wr_data = '0; a_issue_en = 0; a_issue_idx = '0; a_clr = 0;
    b_rs_idx = '0; b_wr_en = 0; b_wr_idx = '0; b_wr_data = '0; b_issue_en = 0; b_issue_idx = '0; b_clr = 0;
    c_rs_idx = '0; c_wr_en = 0; c_wr_idx = '0; c_wr_data = '0; c_issue_en = 0; c_issue_idx = '0; c_clr = 0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) dut_a.regs[i] = 64'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) dut_b.regs[i] = 64'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) dut_c.regs[i] = 32'hDEAD_BEEF;

    @(posedge clk); #1;
    checkOutput("reset ready A", {63'h0, a_ready}, 64'h0);
    checkOutput("reset busy A", {32'h0, a_busy}, 64'h0);
    checkOutput("reset busy B", {44'h0, b_busy}, 64'h0);
    repeat (2) @(posedge clk);

    // Release reset, then reset again partway through the clear.
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midclear ready A", {63'h0, a_ready}, 64'h0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    checkOutput("release ready A", {63'h0, a_ready}, 64'h0);

    first_a = 0; first_b = 0; first_c = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (a_ready && first_a == 0) first_a = k;
      if (b_ready && first_b == 0) first_b = k;
      if (c_ready && first_c == 0) first_c = k;
    end
    checkOutput("clear cycles A", 64'(first_a), 64'd31);
    checkOutput("clear cycles B", 64'(first_b), 64'd19);
    checkOutput("clear cycles C", 64'(first_c), 64'd15);

    // The backdoor pattern must be fully cleared.
    for (int i = 0; i < 32; i++) begin
      a_rs_idx = {5'(31 - i), 5'(i)};
      b_rs_idx = {5'(31 - i), 5'(i)};
      #1;
      checkOutput($sformatf("init A p0 x%0d", i), a_rd[63:0], 64'h0);
      checkOutput($sformatf("init A p1 x%0d", 31 - i), a_rd[127:64], 64'h0);
      checkOutput($sformatf("init B p0 x%0d", i), b_rd[63:0], 64'h0);
    end
    for (int i = 0; i < 16; i++) begin
      c_rs_idx = {4'(i), 4'(15 - i), 4'(i)};
      #1;
      checkOutput($sformatf("init C p1 x%0d", 15 - i), {32'h0, c_rd[63:32]}, 64'h0);
      checkOutput($sformatf("init C p2 x%0d", i), {32'h0, c_rd[95:64]}, 64'h0);
    end

    for (int n = 0; n < 13; n++) applyStimulus(vecs[n], n);
    @(negedge clk);
    a_wr_en = 0; a_issue_en = 0;

    // No-bypass and out-of-range behaviour on instance B.
    b_wr_en = 1; b_wr_idx = 5'd7; b_wr_data = 64'h1111; b_rs_idx = {5'd0, 5'd7};
    #1 checkOutput("B nobyp first", b_rd[63:0], 64'h0);
    @(negedge clk);
    b_wr_data = 64'hA5A5; b_rs_idx = {5'd7, 5'd7};
    #1 checkOutput("B nobyp old", b_rd[127:64], 64'h1111);
    @(negedge clk);
    b_wr_en = 0;
    #1 checkOutput("B nobyp new", b_rd[127:64], 64'hA5A5);
    @(negedge clk);
    b_wr_en = 1; b_wr_idx = 5'd25; b_wr_data = 64'h25; b_issue_en = 1; b_issue_idx = 5'd25;
    @(posedge clk); #1;
    checkOutput("B oor issue busy", {44'h0, b_busy}, 64'h0);
    @(negedge clk);
    b_wr_idx = 5'd19; b_wr_data = 64'h19; b_issue_idx = 5'd19; b_rs_idx = {5'd25, 5'd19};
    #1;
    checkOutput("B x19 nobyp", b_rd[63:0], 64'h0);
    checkOutput("B x25 read", b_rd[127:64], 64'h0);
    @(posedge clk); #1;
    checkOutput("B busy x19", {44'h0, b_busy}, 64'h8_0000);
    @(negedge clk);
    b_wr_en = 0; b_issue_en = 0;
    #1;
    checkOutput("B x19 stored", b_rd[63:0], 64'h19);
    checkOutput("B x25 dropped", b_rd[127:64], 64'h0);

    // Requested clear on instance A, with a late write and a repeat clr_i
    // that must both be ignored.
    a_issue_en = 1; a_issue_idx = 5'd20;
    @(posedge clk); #1;
    checkOutput("A busy x20", {32'h0, a_busy}, 64'h10_0000);
    @(negedge clk);
    a_issue_en = 0; a_clr = 1;
    @(posedge clk); #1;
    checkOutput("clr ready", {63'h0, a_ready}, 64'h0);
    checkOutput("clr busy", {32'h0, a_busy}, 64'h0);
    first_a = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      a_clr     = (k == 5);
      a_wr_en   = (k == 15);
      a_wr_idx  = 5'd9;
      a_wr_data = 64'h99;
      if (k == 2) begin
        a_rs_idx = {5'd7, 5'd5};
        #1;
        checkOutput("clr read x5", a_rd[63:0], 64'h0);
        checkOutput("clr read x7", a_rd[127:64], 64'h0);
      end
      @(posedge clk); #1;
      if (a_ready && first_a == 0) first_a = k;
    end
    checkOutput("clr cycles A", 64'(first_a), 64'd31);
    for (int i = 1; i < 32; i++) begin
      a_rs_idx = {5'(i), 5'(i)};
      #1;
      checkOutput($sformatf("clr A x%0d", i), a_rd[63:0], 64'h0);
    end

    // Top index on the narrow three-port instance.
    @(negedge clk);
    c_wr_en = 1; c_wr_idx = 4'd15; c_wr_data = 32'hCAFE_F00D; c_rs_idx = {4'd15, 4'd15, 4'd15};
    #1;
    for (int p = 0; p < 3; p++)
      checkOutput($sformatf("C byp p%0d", p), {32'h0, c_rd[p*32 +: 32]}, 64'hCAFE_F00D);
    @(negedge clk);
    c_wr_en = 0; c_issue_en = 1; c_issue_idx = 4'd15;
    #1;
    for (int p = 0; p < 3; p++)
      checkOutput($sformatf("C x15 p%0d", p), {32'h0, c_rd[p*32 +: 32]}, 64'hCAFE_F00D);
    @(posedge clk); #1;
    checkOutput("C busy x15", {48'h0, c_busy}, 64'h8000);
    @(negedge clk);
    c_issue_en = 0; c_rs_idx = {4'd14, 4'd0, 4'd15};
    #1;
    checkOutput("C mix p0", {32'h0, c_rd[31:0]}, 64'hCAFE_F00D);
    checkOutput("C mix p1", {32'h0, c_rd[63:32]}, 64'h0);
    checkOutput("C mix p2", {32'h0, c_rd[95:64]}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the RV64I 31x64 register file: configurable width, depth and read-port count.
- Writes are on posedge with optional same-cycle write-to-read bypass.
- A per-register busy scoreboard supports the issue stage.
- A hardware clear engine zeroes the array after reset or on request, so the storage itself needs no reset and maps to flop arrays or latch-RAM.
- Sits between decode (reads, issue), writeback (writes) and the hazard unit (busy_o).

Parameters:
XLEN, 64, data width of each register
NUM_REGS, 32, architectural register count including x0 (legal range 2..64)
NUM_RD, 2, number of asynchronous read ports (1..4)
BYPASS, 1, 1 = a same-cycle write is visible on matching read ports; 0 = no bypass
IDX_W, $clog2(NUM_REGS), index width (derived; not to be overridden)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
rs_idx_i  input  NUM_RD*IDX_W  packed read indices, port p at [p*IDX_W +: IDX_W]
rs_data_ao  output  NUM_RD*XLEN  packed read data (async), port p at [p*XLEN +: XLEN]
wr_en_i  input  1  write strobe
wr_idx_i  input  IDX_W  destination index
wr_data_i  input  XLEN  write data
issue_en_i  input  1  mark issue_idx_i busy (instruction with destination issued)
issue_idx_i  input  IDX_W  destination index being issued
clr_i  input  1  request full array clear (single-cycle pulse)
ready_o  output  1  1 = array valid; clear engine idle
busy_o  output  NUM_REGS  per-register pending-write bit; bit 0 always 0

Behaviour:
- Reset (rst_ni=0):
  - FSM -> CLEAR, clear counter -> 1, ready_o=0, busy_o all 0.
  - Storage array is not reset.
- FSM states:
  - CLEAR:
    - Each cycle writes 0 to entry[counter], then counter increments.
    - When counter == NUM_REGS-1 is written, go to IDLE next cycle.
    - Clear therefore takes NUM_REGS-1 cycles after rst_ni rises; ready_o rises on the following edge (31 cycles for the default configuration).
  - IDLE:
    - ready_o=1.
    - clr_i=1 -> CLEAR, counter=1, ready_o=0 next cycle, busy_o cleared to all 0.
    - clr_i is ignored while in CLEAR (no restart).
- Write:
  - Accepted only when ready_o=1, wr_en_i=1, wr_idx_i != 0 and wr_idx_i < NUM_REGS.
  - Array updates on the rising edge.
  - Writes to x0, out-of-range indices, or while in CLEAR are dropped silently.
- Read, per port (combinational):
  - Index 0, out-of-range index, or ready_o=0 -> 0.
  - Else, if BYPASS=1 and an accepted write targets the same index this cycle -> wr_data_i.
  - Else -> the stored entry.
  - All ports are independent; any number may read the same index.
- Scoreboard:
  - Accepted issue (ready_o=1, issue_en_i=1, idx != 0, in range) sets busy[idx] at the edge.
  - Accepted write clears busy[wr_idx].
  - Issue and write to the same idx in the same cycle -> busy stays 1 (the new producer wins).
  - Issue and write to different idx in the same cycle -> both take effect.
  - busy_o is a registered output.
- Reset mid-clear: the clear restarts from counter=1 after rst_ni rises.

Test Plan:
1. Release reset -> ready_o=0 for exactly 31 cycles, then 1. All ports read 0 for every index 1..31 (array pre-filled by backdoor with 0xDEAD_BEEF before reset).
2. Write x5=0x0123_4567_89AB_CDEF; next cycle read x5 on port 0 and port 1 -> both 0x0123_4567_89AB_CDEF. Write x0=0xFF..FF -> x0 still reads 0.
3. BYPASS=1: write x7=0xA5A5 while port 1 reads x7 in the same cycle -> port 1 shows 0xA5A5 combinationally. Repeat with BYPASS=0 -> old value, and the new value on the next cycle.
4. Issue x3 -> busy_o[3]=1 next cycle. Write x3 and issue x3 in the same cycle -> busy_o[3] stays 1. Write x3 alone -> busy_o[3]=0. Issue x0 -> busy_o[0] stays 0.
5. With registers loaded, pulse clr_i -> ready_o=0 next cycle, busy_o=0. A write to x9 during CLEAR is dropped. After 31 cycles all entries read 0.
6. Params XLEN=32, NUM_REGS=16, NUM_RD=3: clear takes 15 cycles. Index 15 writes and reads correctly on all 3 ports.
